// File: rtl/fp_regfile_sb.sv
// FPU register file: NRD bypassed read ports, two write ports, optional issue scoreboard.
// Define FP_RF_SCOREBOARD_EN to build the pend array, rbusy and busy_cnt; otherwise they tie to 0.
module fp_regfile_sb #(
    parameter int unsigned    DW        = 32,
    parameter int unsigned    AW        = 5,
    parameter int unsigned    NRD       = 2,
    parameter int unsigned    INIT_ADDR = 2,
    parameter logic [DW-1:0]  INIT_VAL  = 'h100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRD*AW-1:0] i_ra,
    output logic [NRD*DW-1:0] o_rd,
    output logic [NRD-1:0]    o_rbusy,
    input  logic              i_wen0,
    input  logic [AW-1:0]     i_wa0,
    input  logic [DW-1:0]     i_wd0,
    input  logic              i_wen1,
    input  logic [AW-1:0]     i_wa1,
    input  logic [DW-1:0]     i_wd1,
    input  logic              i_iss_en,
    input  logic [AW-1:0]     i_iss_wa,
    output logic [AW:0]       o_busy_cnt,
    output logic              o_wcoll
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] r_data [DEPTH];
    logic          r_wcoll;
    logic          w_we0;
    logic          w_we1;

    assign w_we0 = i_wen0 && (i_wa0 != '0);
    assign w_we1 = i_wen1 && (i_wa1 != '0);

    // Port 1 is applied first so port 0 wins on an address collision.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= (INIT_ADDR != 0 && i == INIT_ADDR) ? INIT_VAL : '0;
            end
        end else begin
            if (w_we1) r_data[i_wa1] <= i_wd1;
            if (w_we0) r_data[i_wa0] <= i_wd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_wcoll <= 1'b0;
        else        r_wcoll <= w_we0 && w_we1 && (i_wa0 == i_wa1);
    end

    assign o_wcoll = r_wcoll;

`ifdef FP_RF_SCOREBOARD_EN
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_pend_d;
    logic [AW:0]      r_busy_cnt;
    logic [AW:0]      w_cnt_d;

    // Issue has priority over a clearing write: the new writer owns the register.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_iss_en && i_iss_wa != '0) w_set[i_iss_wa] = 1'b1;
        if (w_we0) w_clr[i_wa0] = 1'b1;
        if (w_we1) w_clr[i_wa1] = 1'b1;
        w_pend_d = w_set | (r_pend & ~w_clr);
        w_cnt_d  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_cnt_d = w_cnt_d + {{AW{1'b0}}, w_pend_d[i]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_pend     <= w_pend_d;
            r_busy_cnt <= w_cnt_d;
        end
    end

    assign o_busy_cnt = r_busy_cnt;
`else
    logic w_unused_iss;
    assign w_unused_iss = ^{i_iss_en, i_iss_wa};
    assign o_busy_cnt   = '0;
`endif

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit0;
        logic          w_hit1;

        assign w_addr = i_ra[k*AW +: AW];
        assign w_hit0 = w_we0 && (i_wa0 == w_addr);
        assign w_hit1 = w_we1 && (i_wa1 == w_addr);
        assign o_rd[k*DW +: DW] = (w_addr == '0) ? '0 :
                                  w_hit0 ? i_wd0 :
                                  w_hit1 ? i_wd1 : r_data[w_addr];
`ifdef FP_RF_SCOREBOARD_EN
        assign o_rbusy[k] = r_pend[w_addr] & ~(w_hit0 | w_hit1);
`else
        assign o_rbusy[k] = 1'b0;
`endif
    end

endmodule
